// File: rtl/write_back_pkg.sv
// Shared types and constants for the write-back stage.
//   write_back_select_t     : which source feeds the register-file write
//   reg_file_write_params_t : decoded write enable + destination register
//   wb_state_t              : stage FSM states
//   LOAD_*                  : load funct3 encodings
package write_back_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC  = 2'd2
    } write_back_select_t;

    typedef struct packed {
        logic       write_enable;
        logic [4:0] addr_rd;
    } reg_file_write_params_t;

    typedef enum logic {
        WB_IDLE,
        WB_WAIT_MEM
    } wb_state_t;

    localparam logic [2:0] LOAD_LB  = 3'd0;
    localparam logic [2:0] LOAD_LH  = 3'd1;
    localparam logic [2:0] LOAD_LW  = 3'd2;
    localparam logic [2:0] LOAD_LBU = 3'd4;
    localparam logic [2:0] LOAD_LHU = 3'd5;

endpackage

// File: rtl/write_back_stage_if.sv
// Execute -> write-back instruction handshake.
//   master (execute): in_valid, wb_params, wb_sel, alu_result, pc, load_funct3
//   slave  (write-back): in_ready
interface write_back_stage_if #(parameter int XLEN = 32);
    import write_back_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    reg_file_write_params_t wb_params;
    write_back_select_t     wb_sel;
    logic [XLEN-1:0]        alu_result;
    logic [XLEN-1:0]        pc;
    logic [2:0]             load_funct3;

    modport master (
        output in_valid, wb_params, wb_sel, alu_result, pc, load_funct3,
        input  in_ready
    );

    modport slave (
        input  in_valid, wb_params, wb_sel, alu_result, pc, load_funct3,
        output in_ready
    );

endinterface

// File: rtl/write_back_stage_load_extend.sv
// Load data extraction: picks the byte/halfword lane out of the aligned
// memory word and sign- or zero-extends it.
//   word       : aligned read word
//   offset     : effective address [1:0]
//   funct3     : load width/sign
//   data       : extended result (0 for unsupported funct3)
//   bad_funct3 : funct3 is not a defined load
module load_extend
    import write_back_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            bad_funct3
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        data       = '0;
        bad_funct3 = 1'b0;
        byte_v     = word[{offset, 3'b000} +: 8];
        // Halfword lane comes from offset[1] only; misaligned bit 0 is dropped.
        half_v     = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            LOAD_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
            LOAD_LH:  data = {{(XLEN-16){half_v[15]}}, half_v};
            LOAD_LW:  data = word;
            LOAD_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
            LOAD_LHU: data = {{(XLEN-16){1'b0}}, half_v};
            default:  bad_funct3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/write_back_stage.sv
// Write-back stage: consumes one instruction per handshake, selects ALU /
// load / PC+4 data, drives the register-file write port, waits for load
// responses (with optional timeout) and counts retired instructions.
//   clk, reset    : clock, async active-low reset
//   ex            : execute handshake (slave side)
//   mem_rsp_*     : data-memory read response
//   rf_we/addr/wdata : registered write port (also the bypass source)
//   busy          : load outstanding
//   load_fault    : one-cycle pulse on bad funct3 or response timeout
//   retire_count  : committed instructions
module write_back_stage
    import write_back_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int RET_CNT_W   = 64,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    write_back_stage_if.slave    ex,
    input  logic                 mem_rsp_valid,
    input  logic [XLEN-1:0]      mem_rsp_data,
    output logic                 rf_we,
    output logic [4:0]           rf_addr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 busy,
    output logic                 load_fault,
    output logic [RET_CNT_W-1:0] retire_count
);

    localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    wb_state_t              state_q, state_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    reg_file_write_params_t pend_q, pend_d;
    logic [2:0]             pend_f3_q, pend_f3_d;
    logic [1:0]             pend_off_q, pend_off_d;

    logic                   rf_we_q;
    logic [4:0]             rf_addr_q;
    logic [XLEN-1:0]        rf_wdata_q;
    logic                   fault_q;
    logic [RET_CNT_W-1:0]   retire_q;

    logic                   commit;
    logic                   c_we;
    logic [4:0]             c_addr;
    logic [XLEN-1:0]        c_data;
    logic                   fault_d;
    logic [XLEN-1:0]        ext_data;
    logic                   ext_bad;

    load_extend #(.XLEN(XLEN)) u_ext (
        .word       (mem_rsp_data),
        .offset     (pend_off_q),
        .funct3     (pend_f3_q),
        .data       (ext_data),
        .bad_funct3 (ext_bad)
    );

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        pend_d     = pend_q;
        pend_f3_d  = pend_f3_q;
        pend_off_d = pend_off_q;
        commit     = 1'b0;
        c_we       = 1'b0;
        c_addr     = '0;
        c_data     = '0;
        fault_d    = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (ex.in_valid) begin
                    if (ex.wb_sel == WB_SEL_MEM) begin
                        state_d    = WB_WAIT_MEM;
                        tmo_d      = '0;
                        pend_d     = ex.wb_params;
                        pend_f3_d  = ex.load_funct3;
                        pend_off_d = ex.alu_result[1:0];
                    end else begin
                        commit = 1'b1;
                        c_we   = ex.wb_params.write_enable && (ex.wb_params.addr_rd != 5'd0);
                        c_addr = ex.wb_params.addr_rd;
                        c_data = (ex.wb_sel == WB_SEL_PC) ? ex.pc + XLEN'(4) : ex.alu_result;
                    end
                end
            end
            WB_WAIT_MEM: begin
                // A response on the terminal-count cycle is taken, not faulted.
                if (mem_rsp_valid) begin
                    state_d = WB_IDLE;
                    commit  = 1'b1;
                    c_we    = pend_q.write_enable && (pend_q.addr_rd != 5'd0);
                    c_addr  = pend_q.addr_rd;
                    c_data  = ext_data;
                    fault_d = ext_bad;
                end else if (MEM_TIMEOUT != 0) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = WB_IDLE;
                        fault_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= WB_IDLE;
            tmo_q      <= '0;
            pend_q     <= '0;
            pend_f3_q  <= '0;
            pend_off_q <= '0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            fault_q    <= 1'b0;
            retire_q   <= '0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            pend_q     <= pend_d;
            pend_f3_q  <= pend_f3_d;
            pend_off_q <= pend_off_d;
            rf_we_q    <= c_we;
            fault_q    <= fault_d;
            if (commit) begin
                rf_addr_q  <= c_addr;
                rf_wdata_q <= c_data;
                retire_q   <= retire_q + RET_CNT_W'(1);
            end
        end
    end

    assign ex.in_ready    = (state_q == WB_IDLE);
    assign busy           = (state_q == WB_WAIT_MEM);
    assign rf_we          = rf_we_q;
    assign rf_addr        = rf_addr_q;
    assign rf_wdata       = rf_wdata_q;
    assign load_fault     = fault_q;
    assign retire_count   = retire_q;

endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
Consumer end of the write-back control interface. It accepts one instruction per handshake from execute, together with its decoded reg_file_write_params_t and write_back_select_t. It selects the ALU result, the aligned and extended load data, or PC+4, and drives the single register-file write port. For loads it stalls in a wait state until the data-memory response arrives. It also maintains the retired-instruction counter.

Parameters:
XLEN, 32, datapath width
RET_CNT_W, 64, width of retired-instruction counter
MEM_TIMEOUT, 255, max cycles waiting for a memory response before a fault is flagged (0 = no timeout)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  execute presents an instruction
in_ready  out  1  stage can accept this cycle
wb_params  in  reg_file_write_params_t  write_enable + addr_rd
wb_sel  in  write_back_select_t  ALU / MEM / PC
alu_result  in  XLEN  ALU output, also the load effective address
pc  in  XLEN  instruction PC
load_funct3  in  3  load width/sign (LB=0, LH=1, LW=2, LBU=4, LHU=5)
mem_rsp_valid  in  1  data-memory read data valid
mem_rsp_data  in  XLEN  aligned 32-bit word read
rf_we  out  1  register-file write enable
rf_addr  out  5  destination register
rf_wdata  out  XLEN  write data
busy  out  1  load outstanding (state WAIT_MEM)
load_fault  out  1  one-cycle pulse: bad funct3 or timeout
retire_count  out  RET_CNT_W  instructions committed

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rf_we=0, rf_addr=0, rf_wdata=0, busy=0, load_fault=0, retire_count=0, timeout counter=0. Reset mid-WAIT_MEM discards the pending load and commits nothing.
- States: IDLE and WAIT_MEM.
- in_ready=1 only in IDLE.
- Accept occurs when in_valid && in_ready.
- Accept with wb_sel ALU or PC: on the next edge, register rf_we=write_enable && (addr_rd!=0), rf_addr=addr_rd, and rf_wdata=alu_result or pc+4. pc+4 wraps modulo 2^XLEN. Latency is 1 cycle from accept to rf_* valid. rf_* hold for exactly one cycle unless another commit follows.
- Accept with wb_sel MEM: latch addr_rd, write_enable, funct3 and alu_result[1:0], then go to WAIT_MEM. busy=1. rf_we=0 while waiting.
- WAIT_MEM with mem_rsp_valid=1: go to IDLE and commit the extracted data on the next edge.
- Load data extraction:
  - Byte lane = offset[1:0] for LB/LBU.
  - Halfword = offset[1] for LH/LHU; offset[0] is ignored.
  - LW ignores the offset.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - funct3 values 3, 6, 7: write 0 and pulse load_fault with the commit.
- mem_rsp_valid in IDLE is ignored and causes no write.
- in_valid during WAIT_MEM is not accepted (in_ready=0). Execute must hold its inputs.
- A response and the next accept never overlap. The earliest back-to-back case is: response edge → IDLE, accept in the following cycle.
- Timeout (MEM_TIMEOUT>0): the counter increments each WAIT_MEM cycle without a response. When it reaches MEM_TIMEOUT: go to IDLE, rf_we=0, pulse load_fault, do not increment retire_count. A response arriving on the same cycle as the terminal count wins.
- x0: rf_we is never 1 with rf_addr=0.
- retire_count increments by 1 on each commit edge, including write_enable=0 (store/branch). It wraps at 2^RET_CNT_W.
- rf_* outputs are registered and double as the bypass source for earlier stages.

Decomposition:
- write_back_pkg:
  - write_back_select_t
  - reg_file_write_params_t
  - wb_state_t {WB_IDLE, WB_WAIT_MEM}
  - load funct3 constants LOAD_LB…LOAD_LHU
- Sub-module load_extend: combinational (word, offset, funct3) → (data, bad_funct3). Verified standalone.

Test Plan:
- ALU op, addr_rd=5, alu_result=0x1234 → next cycle rf_we=1, rf_addr=5, rf_wdata=0x1234; retire_count 0→1.
- JAL, pc=0xFFFFFFFC, addr_rd=1 → rf_wdata=0x00000000 (wrap); in_ready stays 1 for a back-to-back accept.
- LB, offset=3, response after 4 cycles with data 0x80FF_0000 → in_ready=0 and busy=1 for 4 cycles, then rf_wdata=0xFFFFFF80. Repeat with LBU → 0x00000080.
- LHU, offset=2, data 0xBEEF_1234 → 0x0000BEEF; funct3=3 → rf_wdata=0, load_fault pulses once.
- Store (write_enable=0) and ALU op with addr_rd=0 → rf_we stays 0, retire_count +2.
- Load, no response, MEM_TIMEOUT=8 → load_fault on cycle 8, state IDLE, retire_count unchanged. Separately, assert reset mid-wait → all outputs 0 asynchronously, the late response is ignored.
